// File: rtl/cmp_pkg.sv
// ============================================================================
// cmp_pkg
// Shared FSM state encoding and default sizing for the window min/max tracker.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int c_DEFAULT_WIDTH  = 4;
  localparam int c_DEFAULT_WINDOW = 4;

endpackage

`default_nettype wire

// File: rtl/mag_comparator_n.sv
// ============================================================================
// mag_comparator_n
// Combinational unsigned magnitude comparator producing greater/equal/lesser.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mag_comparator_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_greater_b,
  output logic             a_equal_b,
  output logic             a_lesser_b
);

  assign a_greater_b = (a > b);
  assign a_equal_b   = (a == b);
  assign a_lesser_b  = (a < b);

endmodule

`default_nettype wire

// File: rtl/window_minmax_tracker.sv
// ============================================================================
// window_minmax_tracker
// Tracks running max/min over WINDOW accepted samples, then pulses done.
// Revision: 1.0
// ============================================================================
`default_nettype none

module window_minmax_tracker
  import cmp_pkg::*;
#(
  parameter int WIDTH  = c_DEFAULT_WIDTH,
  parameter int WINDOW = c_DEFAULT_WINDOW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic [WIDTH-1:0]           max_out,
  output logic [WIDTH-1:0]           min_out,
  output logic [$clog2(WINDOW+1)-1:0] count,
  output logic                       busy,
  output logic                       done
);

  localparam int CW = $clog2(WINDOW + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;

  logic            w_accept;
  logic [CW-1:0]   w_count_inc;
  logic            w_last;
  logic            w_max_gt, w_max_eq, w_max_lt;
  logic            w_min_gt, w_min_eq, w_min_lt;
  logic            w_unused_cmp;

  mag_comparator_n #(.WIDTH(WIDTH)) u_cmp_max (
    .a           (in_data),
    .b           (r_max),
    .a_greater_b (w_max_gt),
    .a_equal_b   (w_max_eq),
    .a_lesser_b  (w_max_lt)
  );

  mag_comparator_n #(.WIDTH(WIDTH)) u_cmp_min (
    .a           (in_data),
    .b           (r_min),
    .a_greater_b (w_min_gt),
    .a_equal_b   (w_min_eq),
    .a_lesser_b  (w_min_lt)
  );

  // Only "greater than max" and "less than min" move the registers.
  assign w_unused_cmp = w_max_eq ^ w_max_lt ^ w_min_gt ^ w_min_eq;

  assign w_accept    = (r_state == ST_TRACK) && in_valid;
  assign w_count_inc = r_count + 1'b1;
  assign w_last      = (w_count_inc == CW'(WINDOW));

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_TRACK;
      end
      ST_TRACK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_max   <= '0;
      r_min   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && start) begin
        r_count <= '0;
      end
      if (w_accept) begin
        r_count <= w_count_inc;
        // First sample of a window reloads both extremes.
        if (r_count == '0) begin
          r_max <= in_data;
          r_min <= in_data;
        end else begin
          if (w_max_gt) r_max <= in_data;
          if (w_min_lt) r_min <= in_data;
        end
      end
    end
  end

  assign max_out = r_max;
  assign min_out = r_min;
  assign count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_window_minmax_tracker.sv
// ============================================================================
// tb_window_minmax_tracker
// Scoreboard bench: stimulus queues expected window results, monitor checks on done.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_window_minmax_tracker;

  localparam int WIDTH  = 4;
  localparam int WINDOW = 4;
  localparam int CW     = $clog2(WINDOW + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] max_out;
  logic [WIDTH-1:0] min_out;
  logic [CW-1:0]    count;
  logic             busy;
  logic             done;

  window_minmax_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .max_out  (max_out),
    .min_out  (min_out),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mx;
    int mn;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued window result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      check("done_single_cycle", int'(prev_done), 0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_unexpected: got done=1, expected no window pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("win_max", int'(max_out), e.mx);
        check("win_min", int'(min_out), e.mn);
        check("win_count", int'(count), e.cnt);
        check("done_in_ready", int'(in_ready), 0);
        check("done_busy", int'(busy), 0);
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    int t;
    t        = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 20 cycles");
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_window(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                            input int g0, input int g1, input int g2,
                            input int emx, input int emn);
    logic [WIDTH-1:0] s [4];
    int g [3];
    s = '{a, b, c, d};
    g = '{g0, g1, g2};
    sb.push_back('{emx, emn, WINDOW});
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(s[i]);
      if (i < 3) begin
        check("mid_count", int'(count), i + 1);
        repeat (g[i]) tick();
        check("gap_count_hold", int'(count), i + 1);
      end
    end
    check("done_latency", int'(done), 1);
    tick();
    check("idle_after_done", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic check_reset_values();
    check("rst_max", int'(max_out), 0);
    check("rst_min", int'(min_out), 0);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_ready", int'(in_ready), 0);
  endtask

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Test 1: get into a mid-window state, then hold reset two cycles
    do_start();
    send(4'd3);
    send(4'd11);
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();

    // Test 6b: in_valid in IDLE without start is ignored
    in_valid = 1'b1;
    in_data  = 4'd9;
    repeat (3) tick();
    check("idle_in_ready", int'(in_ready), 0);
    check("idle_count", int'(count), 0);
    check("idle_max", int'(max_out), 0);
    in_valid = 1'b0;
    tick();

    // Test 2: back-to-back
    run_window(4'd5, 4'd2, 4'd9, 4'd2, 0, 0, 0, 9, 2);

    // Test 3: equal samples with gaps
    run_window(4'd7, 4'd7, 4'd7, 4'd7, 1, 3, 2, 7, 7);

    // Test 4: extremes, then a window that must reload from its first sample
    run_window(4'd15, 4'd0, 4'd15, 4'd0, 0, 1, 0, 15, 0);
    run_window(4'd3, 4'd4, 4'd3, 4'd4, 0, 0, 0, 4, 3);
    repeat (3) tick();
    check("idle_hold_max", int'(max_out), 4);
    check("idle_hold_min", int'(min_out), 3);
    check("idle_hold_count", int'(count), 4);

    // Test 5: reset after two accepts discards the window
    do_start();
    send(4'd6);
    send(4'd1);
    rst_n = 1'b0;
    tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();
    check("post_rst_done", int'(done), 0);
    run_window(4'd1, 4'd8, 4'd6, 4'd3, 0, 0, 0, 8, 1);

    // Test 6: start during TRACK is ignored
    sb.push_back('{12, 4, WINDOW});
    do_start();
    send(4'd6);
    send(4'd10);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("track_start_count", int'(count), 2);
    check("track_start_busy", int'(busy), 1);
    send(4'd4);
    send(4'd12);
    check("t6_done_latency", int'(done), 1);
    tick();
    check("t6_sb_drained", sb.size(), 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
